// File: rtl/pipe_stall_sched_pkg.sv
// ----------------------------------------------------------------------------
// pipe_stall_sched_pkg
// Shared definitions for the pipeline stall/flush scheduler:
//   - StallBus bit indices (bit0=PC .. bit5=WB) and stall pattern constants
//   - divider sequencing FSM state encoding
//   - saturating increment helpers for the watchdog and perf counters
// No ports (package).
// ----------------------------------------------------------------------------
package pipe_stall_sched_pkg;

   localparam int STALL_BIT_PC  = 0;
   localparam int STALL_BIT_IF  = 1;
   localparam int STALL_BIT_ID  = 2;
   localparam int STALL_BIT_EX  = 3;
   localparam int STALL_BIT_MEM = 4;
   localparam int STALL_BIT_WB  = 5;

   // Holding PC/IF/ID leaves EX without a producer, so EX loads a bubble.
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_LU   = 6'b000111;
   // Holding up to EX keeps the divide in EX; MEM loads a bubble.
   localparam logic [5:0] STALL_DIV  = 6'b001111;

   typedef enum logic [1:0] {
      SCHED_IDLE = 2'd0,
      SCHED_BUSY = 2'd1,
      SCHED_DONE = 2'd2
   } sched_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pipe_stall_sched_hz_loaduse_detect.sv
// ----------------------------------------------------------------------------
// hz_loaduse_detect
// Purely combinational load-use hazard compare between the load in EX and the
// source operands of the instruction in ID. Register 0 never creates a hazard.
// Ports:
//   id_rs, id_rt           ID source register numbers
//   id_rs_used, id_rt_used ID instruction actually reads rs / rt
//   ex_is_load             EX instruction is a load
//   ex_wreg                EX destination register
//   lu_hit                 hazard present this cycle
// ----------------------------------------------------------------------------
module hz_loaduse_detect #(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_wreg,
   output logic              lu_hit
);

   assign lu_hit = ex_is_load && (ex_wreg != '0) &&
                   ((id_rs_used && (id_rs == ex_wreg)) ||
                    (id_rt_used && (id_rt == ex_wreg)));

endmodule

// File: rtl/pipe_stall_sched.sv
// ----------------------------------------------------------------------------
// pipe_stall_sched
// Stall/flush scheduler for the 5-stage core. Merges three sources onto the
// StallBus: MEM exception redirect (highest), the divider start/busy/done
// sequence with watchdog, and the load-use hazard (lowest).
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   id_rs/id_rt(_used)       ID operand info for load-use detection
//   ex_is_load, ex_wreg      EX load info
//   ex_div_req, div_ready    divider request from EX / result-valid pulse
//   mem_excp, mem_new_pc     exception redirect from MEM
//   stall                    StallBus, bit i holds stage i register
//   flush, new_pc            kill IF/ID/EX and redirect IF
//   div_start/cancel/timeout divider control pulses
// Optional build macro PIPE_PERF_CNT_EN adds saturating 32-bit cycle counters
// perf_lu_stall, perf_div_stall and perf_flush as outputs.
// All outputs are forced to 0 while rst is asserted.
// ----------------------------------------------------------------------------
module pipe_stall_sched
   import pipe_stall_sched_pkg::*;
#(
   parameter int STALL_W     = 6,
   parameter int REG_AW      = 5,
   parameter int DIV_MAX_CYC = 40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REG_AW-1:0]  id_rs,
   input  logic [REG_AW-1:0]  id_rt,
   input  logic               id_rs_used,
   input  logic               id_rt_used,
   input  logic               ex_is_load,
   input  logic [REG_AW-1:0]  ex_wreg,
   input  logic               ex_div_req,
   input  logic               div_ready,
   input  logic               mem_excp,
   input  logic [31:0]        mem_new_pc,
`ifdef PIPE_PERF_CNT_EN
   output logic [31:0]        perf_lu_stall,
   output logic [31:0]        perf_div_stall,
   output logic [31:0]        perf_flush,
`endif
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic [31:0]        new_pc,
   output logic               div_start,
   output logic               div_cancel,
   output logic               div_timeout
);

   sched_state_e state_q, state_d;
   logic [7:0]   wdog_q, wdog_d;
   logic         lu_hit_s;
   logic         div_stall_s;
   logic         div_start_s, div_cancel_s, div_timeout_s;
   logic [5:0]   stall_s;

   hz_loaduse_detect #(.REG_AW(REG_AW)) u_hz_loaduse_detect (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rs_used (id_rs_used),
      .id_rt_used (id_rt_used),
      .ex_is_load (ex_is_load),
      .ex_wreg    (ex_wreg),
      .lu_hit     (lu_hit_s)
   );

   // Divider FSM state and watchdog registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SCHED_IDLE;
         wdog_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
      end
   end

   // Next state, divider pulses and priority merge of the stall sources.
   always_comb begin
      state_d       = state_q;
      wdog_d        = wdog_q;
      div_stall_s   = 1'b0;
      div_start_s   = 1'b0;
      div_cancel_s  = 1'b0;
      div_timeout_s = 1'b0;
      case (state_q)
         SCHED_IDLE: begin
            if (ex_div_req) begin
               div_start_s = 1'b1;
               div_stall_s = 1'b1;
               wdog_d      = 8'd0;
               state_d     = SCHED_BUSY;
            end else begin
               state_d = SCHED_IDLE;
            end
         end
         SCHED_BUSY: begin
            div_stall_s = 1'b1;
            wdog_d      = sat_inc8(wdog_q);
            // A result arriving on the last allowed cycle still wins.
            if (div_ready) begin
               state_d = SCHED_DONE;
            end else if (wdog_q == 8'(DIV_MAX_CYC - 1)) begin
               div_timeout_s = 1'b1;
               div_cancel_s  = 1'b1;
               div_stall_s   = 1'b0;
               state_d       = SCHED_IDLE;
            end else begin
               state_d = SCHED_BUSY;
            end
         end
         SCHED_DONE: begin
            // EX captures the result this cycle; a still-high request is stale.
            state_d = SCHED_IDLE;
         end
         default: begin
            state_d = SCHED_IDLE;
         end
      endcase

      // The redirect discards everything younger than MEM, including the divide.
      if (mem_excp) begin
         div_cancel_s  = (state_q == SCHED_BUSY);
         div_start_s   = 1'b0;
         div_timeout_s = 1'b0;
         div_stall_s   = 1'b0;
         state_d       = SCHED_IDLE;
         stall_s       = STALL_NONE;
      end else begin
         stall_s = (div_stall_s ? STALL_DIV : STALL_NONE) |
                   (lu_hit_s    ? STALL_LU  : STALL_NONE);
      end
   end

   assign stall       = rst ? '0 : STALL_W'(stall_s);
   assign flush       = rst ? 1'b0 : mem_excp;
   assign new_pc      = (rst || !mem_excp) ? 32'd0 : mem_new_pc;
   assign div_start   = rst ? 1'b0 : div_start_s;
   assign div_cancel  = rst ? 1'b0 : div_cancel_s;
   assign div_timeout = rst ? 1'b0 : div_timeout_s;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] perf_lu_q, perf_div_q, perf_flush_q;

   // Saturating per-cause cycle counters, counting causes that reach the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_lu_q    <= 32'd0;
         perf_div_q   <= 32'd0;
         perf_flush_q <= 32'd0;
      end else begin
         if (lu_hit_s && !mem_excp) begin
            perf_lu_q <= sat_inc32(perf_lu_q);
         end
         if (div_stall_s) begin
            perf_div_q <= sat_inc32(perf_div_q);
         end
         if (mem_excp) begin
            perf_flush_q <= sat_inc32(perf_flush_q);
         end
      end
   end

   assign perf_lu_stall  = perf_lu_q;
   assign perf_div_stall = perf_div_q;
   assign perf_flush     = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_stall_sched.sv
// ----------------------------------------------------------------------------
// tb_pipe_stall_sched
// Scoreboard bench for pipe_stall_sched: each driven cycle pushes its expected
// outputs to a queue; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_stall_sched;

   typedef struct packed {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic        start;
      logic        cancel;
      logic        tout;
   } exp_t;

   logic        clk = 1'b0;
   logic        clk_en = 1'b1;
   logic        rst;
   logic [4:0]  id_rs, id_rt, ex_wreg;
   logic        id_rs_used, id_rt_used, ex_is_load, ex_div_req, div_ready, mem_excp;
   logic [31:0] mem_new_pc;
   logic [5:0]  stall;
   logic        flush, div_start, div_cancel, div_timeout;
   logic [31:0] new_pc;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] perf_lu_stall, perf_div_stall, perf_flush;
`endif

   int   n_checks = 0;
   int   n_fails  = 0;
   exp_t  sb_q[$];
   string tag_q[$];

   pipe_stall_sched #(.STALL_W(6), .REG_AW(5), .DIV_MAX_CYC(40)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rs_used  (id_rs_used),
      .id_rt_used  (id_rt_used),
      .ex_is_load  (ex_is_load),
      .ex_wreg     (ex_wreg),
      .ex_div_req  (ex_div_req),
      .div_ready   (div_ready),
      .mem_excp    (mem_excp),
      .mem_new_pc  (mem_new_pc),
`ifdef PIPE_PERF_CNT_EN
      .perf_lu_stall  (perf_lu_stall),
      .perf_div_stall (perf_div_stall),
      .perf_flush     (perf_flush),
`endif
      .stall       (stall),
      .flush       (flush),
      .new_pc      (new_pc),
      .div_start   (div_start),
      .div_cancel  (div_cancel),
      .div_timeout (div_timeout)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic clr_in();
      id_rs = 5'd0; id_rt = 5'd0; ex_wreg = 5'd0;
      id_rs_used = 1'b0; id_rt_used = 1'b0; ex_is_load = 1'b0;
      ex_div_req = 1'b0; div_ready = 1'b0; mem_excp = 1'b0; mem_new_pc = 32'd0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input string tag, input logic [5:0] s, input logic f,
                           input logic [31:0] pc, input logic st, input logic ca,
                           input logic to);
      exp_t e;
      e.stall = s; e.flush = f; e.pc = pc; e.start = st; e.cancel = ca; e.tout = to;
      sb_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic expect_idle(input string tag);
      push_exp(tag, 6'b000000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Compare DUT outputs against the oldest expected entry, away from posedge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t  e;
         string t;
         e = sb_q.pop_front();
         t = tag_q.pop_front();
         chk_eq({t, ".stall"},   {26'd0, stall},       {26'd0, e.stall});
         chk_eq({t, ".flush"},   {31'd0, flush},       {31'd0, e.flush});
         chk_eq({t, ".new_pc"},  new_pc,               e.pc);
         chk_eq({t, ".start"},   {31'd0, div_start},   {31'd0, e.start});
         chk_eq({t, ".cancel"},  {31'd0, div_cancel},  {31'd0, e.cancel});
         chk_eq({t, ".timeout"}, {31'd0, div_timeout}, {31'd0, e.tout});
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      clr_in();
      rst = 1'b1;
      #12;
      chk_eq("rst.stall", {26'd0, stall}, 32'd0);
      chk_eq("rst.new_pc", new_pc, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1. Load-use through rs, rt, and the register-0 / unused exclusions.
      next_cycle(); ex_is_load = 1'b1; ex_wreg = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1;
      push_exp("lu_rs", 6'b000111, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      next_cycle(); clr_in(); expect_idle("lu_after");
      next_cycle(); ex_is_load = 1'b1; ex_wreg = 5'd0; id_rs = 5'd0; id_rs_used = 1'b1;
      expect_idle("lu_r0");
      next_cycle(); clr_in(); ex_is_load = 1'b1; ex_wreg = 5'd7; id_rt = 5'd7; id_rt_used = 1'b1;
      push_exp("lu_rt", 6'b000111, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      next_cycle(); id_rt_used = 1'b0; expect_idle("lu_rt_unused");
      next_cycle(); clr_in(); id_rs = 5'd9; id_rs_used = 1'b1; ex_wreg = 5'd9;
      expect_idle("lu_noload");

      // 2. Divide with result after 34 BUSY cycles, request held through DONE.
      next_cycle(); clr_in(); ex_div_req = 1'b1;
      push_exp("div_start", 6'b001111, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 33; i++) begin
         next_cycle(); push_exp("div_busy", 6'b001111, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      end
      next_cycle(); div_ready = 1'b1;
      push_exp("div_ready", 6'b001111, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      next_cycle(); div_ready = 1'b0; expect_idle("div_done");
      next_cycle(); ex_div_req = 1'b0; expect_idle("div_idle");

      // 3. Watchdog expiry on BUSY cycle 40; stray div_ready in IDLE ignored.
      next_cycle(); ex_div_req = 1'b1;
      push_exp("wd_start", 6'b001111, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      next_cycle(); ex_div_req = 1'b0;
      push_exp("wd_busy", 6'b001111, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 2; i <= 39; i++) begin
         next_cycle(); push_exp("wd_busy", 6'b001111, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      end
      next_cycle(); push_exp("wd_expire", 6'b000000, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
      next_cycle(); expect_idle("wd_idle");
      next_cycle(); div_ready = 1'b1; expect_idle("idle_ready");
      next_cycle(); div_ready = 1'b0; expect_idle("idle_ready2");

      // 4. Exception in BUSY cancels the divide; exception in IDLE only flushes.
      next_cycle(); ex_div_req = 1'b1;
      push_exp("ex_start", 6'b001111, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         next_cycle(); ex_div_req = 1'b0;
         push_exp("ex_busy", 6'b001111, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      end
      next_cycle(); mem_excp = 1'b1; mem_new_pc = 32'hBFC0_0380;
      push_exp("ex_busy_flush", 6'b000000, 1'b1, 32'hBFC0_0380, 1'b0, 1'b1, 1'b0);
      next_cycle(); clr_in(); div_ready = 1'b1; expect_idle("ex_after");
      next_cycle(); clr_in(); mem_excp = 1'b1; mem_new_pc = 32'h8000_0180;
      push_exp("ex_idle_flush", 6'b000000, 1'b1, 32'h8000_0180, 1'b0, 1'b0, 1'b0);

      // 5. Collision: load-use + divide request + exception in one cycle.
      next_cycle(); clr_in();
      ex_is_load = 1'b1; ex_wreg = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1;
      ex_div_req = 1'b1; mem_excp = 1'b1; mem_new_pc = 32'h0000_1234;
      push_exp("collide", 6'b000000, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
      next_cycle(); clr_in(); expect_idle("collide_after");

      // 6. Asynchronous reset mid-BUSY with the clock stopped.
      next_cycle(); ex_div_req = 1'b1;
      push_exp("rs_start", 6'b001111, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      next_cycle(); ex_div_req = 1'b0;
      push_exp("rs_busy", 6'b001111, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      next_cycle(); push_exp("rs_busy", 6'b001111, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      clk_en = 1'b0;
      #3;
      chk_eq("rs_pre.stall", {26'd0, stall}, 32'h0000_000F);
      rst = 1'b1;
      #1;
      chk_eq("arst.stall",  {26'd0, stall},       32'd0);
      chk_eq("arst.cancel", {31'd0, div_cancel},  32'd0);
      chk_eq("arst.start",  {31'd0, div_start},   32'd0);
      chk_eq("arst.tout",   {31'd0, div_timeout}, 32'd0);
      chk_eq("arst.flush",  {31'd0, flush},       32'd0);
`ifdef PIPE_PERF_CNT_EN
      chk_eq("arst.perf_lu",    perf_lu_stall,  32'd0);
      chk_eq("arst.perf_div",   perf_div_stall, 32'd0);
      chk_eq("arst.perf_flush", perf_flush,     32'd0);
`endif
      #5;
      rst = 1'b0;
      #5;
      clk_en = 1'b1;
      next_cycle(); expect_idle("post_rst_idle");
      next_cycle(); ex_is_load = 1'b1; ex_wreg = 5'd3; id_rt = 5'd3; id_rt_used = 1'b1;
      push_exp("post_rst_lu", 6'b000111, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      next_cycle(); clr_in(); expect_idle("post_rst_end");

      @(negedge clk);
      #1;
      chk_eq("sb_drain", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
